// File: rtl/usb_host_txn_engine_pkg.sv
// USBPkg: shared definitions for the USB host transaction engine.
//   - PID constants used on the tx/rx packet interface
//   - txn_state_e: engine sequencing states
//   - request/response and tx/rx packet header structs
//   - hs_pid(): handshake PID selection (ACK or NAK)
package USBPkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   typedef enum logic [3:0] {
      IDLE,
      A_TOK,
      A_DAT,
      A_WAIT,
      D_TOK,
      D_DAT,
      D_WAIT,
      R_HS,
      DONE
   } txn_state_e;

   // Latched request fields (payload is kept separately since its width is parameterised).
   typedef struct packed {
      logic        write;
      logic [15:0] mempage;
   } txn_req_t;

   // Completion status carried with rsp_valid.
   typedef struct packed {
      logic success;
   } txn_rsp_t;

   // Header of a packet offered to the packet layer.
   typedef struct packed {
      logic [3:0] pid;
      logic [6:0] addr;
      logic [3:0] endp;
   } tx_hdr_t;

   // Header of a packet strobed in from the packet layer.
   typedef struct packed {
      logic       valid;
      logic [3:0] pid;
      logic       crc_ok;
   } rx_hdr_t;

   function automatic logic [3:0] hs_pid(input logic ack);
      return ack ? PID_ACK : PID_NAK;
   endfunction

endpackage

// File: rtl/usb_host_txn_engine_rsp_timer.sv
// usb_rsp_timer: response timeout down-counter.
//   clock, reset : sole clock, synchronous active-high reset
//   clear        : force the counter to zero
//   load         : reload so that expired rises after TIMEOUT_CYCLES enabled cycles
//   enable       : count down (saturates at zero)
//   expired      : counter has reached zero
module usb_rsp_timer #(
   parameter int unsigned  TIMEOUT_CYCLES = 255,
   localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic load,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Loading TIMEOUT_CYCLES-1 makes expired visible during the
   // TIMEOUT_CYCLES-th enabled cycle after the load.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/usb_host_txn_engine.sv
// usb_host_txn_engine: host-side USB transaction sequencer.
// Accepts page READ/WRITE requests (req_*), issues the token/data/handshake
// packet sequence to the packet layer (tx_*), consumes device packets (rx_*),
// retries NAK / bad-CRC / timeout up to MAX_RETRY times per phase and returns
// one status response per request (rsp_*).
//   clock, reset          : sole clock, synchronous active-high reset
//   req_valid/ready/write/mempage/wdata : request handshake and fields
//   rsp_valid/success/rdata             : one-cycle completion and status
//   tx_valid/ready/pid/addr/endp/len/payload : packet to packet layer
//   rx_valid/pid/payload/crc_ok         : received packet strobe
// Optional: `define USB_HOST_TXN_STATS_EN adds stat_retries / stat_failures.
module usb_host_txn_engine
   import USBPkg::*;
#(
   parameter int unsigned  DATA_BYTES     = 8,
   parameter logic [6:0]   DEV_ADDR       = 7'd5,
   parameter logic [3:0]   ENDP_OUT       = 4'd4,
   parameter logic [3:0]   ENDP_IN        = 4'd8,
   parameter int unsigned  MAX_RETRY      = 8,
   parameter int unsigned  TIMEOUT_CYCLES = 255,
   localparam int unsigned W              = 8 * DATA_BYTES,
   localparam int unsigned LEN_W          = $clog2(DATA_BYTES + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [15:0]      req_mempage,
   input  logic [W-1:0]     req_wdata,
   output logic             rsp_valid,
   output logic             rsp_success,
   output logic [W-1:0]     rsp_rdata,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [3:0]       tx_pid,
   output logic [6:0]       tx_addr,
   output logic [3:0]       tx_endp,
   output logic [LEN_W-1:0] tx_len,
   output logic [W-1:0]     tx_payload,
   input  logic             rx_valid,
   input  logic [3:0]       rx_pid,
   input  logic [W-1:0]     rx_payload,
   input  logic             rx_crc_ok
`ifdef USB_HOST_TXN_STATS_EN
   ,
   output logic [15:0]      stat_retries,
   output logic [15:0]      stat_failures
`endif
);

   localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

   txn_state_e   state_q, state_d;
   txn_req_t     req_q, req_d;
   txn_rsp_t     rsp_q, rsp_d;
   logic [W-1:0] wdata_q, wdata_d;
   logic [W-1:0] rdata_q, rdata_d;
   logic [7:0]   attempt_q, attempt_d;
   logic         hs_ack_q, hs_ack_d;

   logic         fail_attempt;
   logic         give_up;
   logic         timer_load;
   logic         timer_enable;
   logic         timer_clear;
   logic         timer_expired;
   tx_hdr_t      tx_hdr;
   rx_hdr_t      rx;

   assign rx = {rx_valid, rx_pid, rx_crc_ok};

   usb_rsp_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rsp_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (timer_clear),
      .load   (timer_load),
      .enable (timer_enable),
      .expired(timer_expired)
   );

   assign timer_enable = (state_q == A_WAIT) || (state_q == D_WAIT);
   assign timer_clear  = (state_q == IDLE);

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      rsp_d        = rsp_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      attempt_d    = attempt_q;
      hs_ack_d     = hs_ack_q;
      fail_attempt = 1'b0;
      give_up      = 1'b0;
      timer_load   = 1'b0;
      tx_valid     = 1'b0;
      tx_hdr       = '0;
      tx_len       = '0;
      tx_payload   = '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d     = '{write: req_write, mempage: req_mempage};
               wdata_d   = req_wdata;
               attempt_d = '0;
               state_d   = A_TOK;
            end
         end

         A_TOK: begin
            tx_valid = 1'b1;
            tx_hdr   = '{pid: PID_OUT, addr: DEV_ADDR, endp: ENDP_OUT};
            if (tx_ready) state_d = A_DAT;
         end

         A_DAT: begin
            tx_valid    = 1'b1;
            tx_hdr.pid  = PID_DATA0;
            tx_len      = LEN_W'(2);
            tx_payload  = W'(req_q.mempage);
            if (tx_ready) begin
               timer_load = 1'b1;
               state_d    = A_WAIT;
            end
         end

         A_WAIT: begin
            if (rx.valid) begin
               if (rx.pid == PID_ACK) begin
                  attempt_d = '0;
                  state_d   = D_TOK;
               end else begin
                  fail_attempt = 1'b1;
               end
            end else if (timer_expired) begin
               fail_attempt = 1'b1;
            end
         end

         D_TOK: begin
            tx_valid = 1'b1;
            tx_hdr   = '{pid:  req_q.write ? PID_OUT : PID_IN,
                         addr: DEV_ADDR,
                         endp: req_q.write ? ENDP_OUT : ENDP_IN};
            if (tx_ready) begin
               if (req_q.write) begin
                  state_d = D_DAT;
               end else begin
                  timer_load = 1'b1;
                  state_d    = D_WAIT;
               end
            end
         end

         D_DAT: begin
            tx_valid   = 1'b1;
            tx_hdr.pid = PID_DATA0;
            tx_len     = LEN_W'(DATA_BYTES);
            tx_payload = wdata_q;
            if (tx_ready) begin
               timer_load = 1'b1;
               state_d    = D_WAIT;
            end
         end

         D_WAIT: begin
            if (rx.valid) begin
               if (req_q.write && (rx.pid == PID_ACK)) begin
                  rsp_d.success = 1'b1;
                  state_d       = DONE;
               end else if (!req_q.write && (rx.pid == PID_DATA0)) begin
                  // A corrupt DATA0 is answered with NAK first; the failed
                  // attempt is counted once that handshake is accepted.
                  hs_ack_d = rx.crc_ok;
                  if (rx.crc_ok) rdata_d = rx_payload;
                  state_d = R_HS;
               end else begin
                  fail_attempt = 1'b1;
               end
            end else if (timer_expired) begin
               fail_attempt = 1'b1;
            end
         end

         R_HS: begin
            tx_valid   = 1'b1;
            tx_hdr.pid = hs_pid(hs_ack_q);
            if (tx_ready) begin
               if (hs_ack_q) begin
                  rsp_d.success = 1'b1;
                  state_d       = DONE;
               end else begin
                  fail_attempt = 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Retry restarts the token of whichever phase failed; R_HS belongs to
      // the data phase.
      if (fail_attempt) begin
         if (attempt_q < RETRY_LIMIT) begin
            attempt_d = attempt_q + 8'd1;
            state_d   = (state_q == A_WAIT) ? A_TOK : D_TOK;
         end else begin
            give_up       = 1'b1;
            rsp_d.success = 1'b0;
            state_d       = DONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         req_q     <= '0;
         rsp_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         attempt_q <= '0;
         hs_ack_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         rsp_q     <= rsp_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         attempt_q <= attempt_d;
         hs_ack_q  <= hs_ack_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == DONE);
   assign rsp_success = rsp_q.success;
   assign rsp_rdata   = rdata_q;
   assign tx_pid      = tx_hdr.pid;
   assign tx_addr     = tx_hdr.addr;
   assign tx_endp     = tx_hdr.endp;

`ifdef USB_HOST_TXN_STATS_EN
   logic [15:0] retries_q, retries_d;
   logic [15:0] failures_q, failures_d;

   always_comb begin
      retries_d  = retries_q;
      failures_d = failures_q;
      if (fail_attempt && (retries_q != '1)) retries_d = retries_q + 16'd1;
      if (give_up && (failures_q != '1)) failures_d = failures_q + 16'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         retries_q  <= '0;
         failures_q <= '0;
      end else begin
         retries_q  <= retries_d;
         failures_q <= failures_d;
      end
   end

   assign stat_retries  = retries_q;
   assign stat_failures = failures_q;
`endif

endmodule
